// File: rtl/fsm_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fsm_pattern_sequencer
// Summary  : Holds x low for a settle window, shifts a captured pattern onto x
//            LSB first, and cross-checks two FSM implementations cycle by cycle.
// Revision : 1.0
// ============================================================================
module fsm_pattern_sequencer #(
  parameter int PATTERN_LEN   = 16,
  parameter int LEN_W         = 5,
  parameter int SETTLE_CYCLES = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PATTERN_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]       length,
  output logic                   x,
  input  logic                   z1_a,
  input  logic                   z2_a,
  input  logic                   z1_b,
  input  logic                   z2_b,
  output logic                   busy,
  output logic                   done,
  output logic                   mismatch,
  output logic [LEN_W-1:0]       mismatch_idx,
  output logic [LEN_W-1:0]       mismatch_count
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_settle_last = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [LEN_W-1:0] c_len_max     = LEN_W'(PATTERN_LEN);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_settle = 3'd1;
  localparam logic [2:0] c_st_drive  = 3'd2;
  localparam logic [2:0] c_st_check  = 3'd3;
  localparam logic [2:0] c_st_done   = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]       length_q, length_d;
  logic [LEN_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   x_q, x_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   mismatch_q, mismatch_d;
  logic [LEN_W-1:0]       mismatch_idx_q, mismatch_idx_d;
  logic [LEN_W-1:0]       mismatch_count_q, mismatch_count_d;

  logic [LEN_W-1:0]       idx_inc;
  logic [LEN_W-1:0]       length_clamped;
  logic                   last_bit;
  logic                   cmp_en;
  logic                   cmp_fail;

  assign idx_inc        = idx_q + LEN_W'(1);
  assign length_clamped = (length > c_len_max) ? c_len_max : length;
  assign last_bit       = (idx_inc == length_q);

  // The FSMs lag x by one cycle, so a compare at this edge judges the bit
  // driven in the previous cycle (idx_q - 1); abort suppresses the compare.
  assign cmp_en   = !abort && (((state_q == c_st_drive) && (idx_q != '0)) ||
                               (state_q == c_st_check));
  assign cmp_fail = cmp_en && ((z1_a != z1_b) || (z2_a != z2_b));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= c_st_idle;
      pattern_q        <= '0;
      length_q         <= '0;
      idx_q            <= '0;
      cnt_q            <= '0;
      x_q              <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      mismatch_q       <= 1'b0;
      mismatch_idx_q   <= '0;
      mismatch_count_q <= '0;
    end else begin
      state_q          <= state_d;
      pattern_q        <= pattern_d;
      length_q         <= length_d;
      idx_q            <= idx_d;
      cnt_q            <= cnt_d;
      x_q              <= x_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      mismatch_q       <= mismatch_d;
      mismatch_idx_q   <= mismatch_idx_d;
      mismatch_count_q <= mismatch_count_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    pattern_d        = pattern_q;
    length_d         = length_q;
    idx_d            = idx_q;
    cnt_d            = cnt_q;
    mismatch_d       = mismatch_q;
    mismatch_idx_d   = mismatch_idx_q;
    mismatch_count_d = mismatch_count_q;

    if (abort) begin
      state_d = c_st_idle;
    end else begin
      case (state_q)
        c_st_idle: begin
          if (start) begin
            pattern_d        = pattern;
            length_d         = length_clamped;
            cnt_d            = '0;
            idx_d            = '0;
            mismatch_d       = 1'b0;
            mismatch_idx_d   = '0;
            mismatch_count_d = '0;
            state_d          = (length == '0) ? c_st_done : c_st_settle;
          end
        end
        c_st_settle: begin
          if (cnt_q == c_settle_last) begin
            state_d = c_st_drive;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        c_st_drive: begin
          idx_d = idx_inc;
          if (last_bit) begin
            state_d = c_st_check;
          end
        end
        c_st_check: state_d = c_st_done;
        c_st_done:  state_d = c_st_idle;
        default:    state_d = c_st_idle;
      endcase
    end

    if (cmp_fail) begin
      mismatch_d = 1'b1;
      if (!mismatch_q) begin
        mismatch_idx_d = idx_q - LEN_W'(1);
      end
      if (mismatch_count_q != '1) begin
        mismatch_count_d = mismatch_count_q + LEN_W'(1);
      end
    end

    // Each launched bit is consumed from the bottom of the shift register.
    if (state_d == c_st_drive) begin
      pattern_d = pattern_q >> 1;
    end
  end

  always_comb begin
    x_d    = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_d == c_st_drive) begin
      x_d = pattern_q[0];
    end
    if ((state_d == c_st_settle) || (state_d == c_st_drive) || (state_d == c_st_check)) begin
      busy_d = 1'b1;
    end
    if (state_d == c_st_done) begin
      done_d = 1'b1;
    end
  end

  assign x              = x_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign mismatch       = mismatch_q;
  assign mismatch_idx   = mismatch_idx_q;
  assign mismatch_count = mismatch_count_q;

endmodule
`default_nettype wire
